// File: rtl/game_pkg.sv
// game_pkg: mode encodings, button indices and sizing helper shared by the
// game-mode controller, its interface and the bench.
package game_pkg;
    typedef enum logic [2:0] {
        MODE_MENU  = 3'd0,
        MODE_PLAY  = 3'd1,
        MODE_PAUSE = 3'd2,
        MODE_LOSE  = 3'd3,
        MODE_WIN   = 3'd4
    } mode_t;

    localparam int BTN_CONFIRM = 0;
    localparam int BTN_PREV    = 1;
    localparam int BTN_NEXT    = 2;
    localparam int BTN_PAUSE   = 3;

    // game_id width: clog2 of the game count, never narrower than one bit
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/game_mode_ctrl_if.sv
// game_mode_ctrl_if: board-pin and renderer-facing signals of the game-mode controller.
interface game_mode_ctrl_if #(
    parameter int NUM_BTN   = 5,
    parameter int NUM_GAMES = 3
);
    import game_pkg::*;
    localparam int GW = gid_w(NUM_GAMES);
    logic [NUM_BTN-1:0] btn_n;
    logic               lose;
    logic               win;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    mode_t              mode;
    logic [GW-1:0]      game_id;
    logic               game_start;
    modport master (
        output btn_n, lose, win,
        input  btn_level, btn_press, mode, game_id, game_start
    );
    modport slave (
        input  btn_n, lose, win,
        output btn_level, btn_press, mode, game_id, game_start
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser, stable-count debounce and press pulse for one
// active-low button; a button held through reset stays ignored until released.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_armed;
    logic                   r_stable;
    logic                   r_press;
    logic [CW-1:0]          r_cnt;
    logic                   w_in;
    logic                   w_flip;

    // until a real released sample has crossed the synchroniser, the pin reads as released
    assign w_in   = r_armed ? r_sync[SYNC_STAGES-1] : 1'b1;
    assign w_flip = (w_in != r_stable) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '1;
            r_fill   <= '0;
            r_armed  <= 1'b0;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
            r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_armed  <= r_armed | (r_fill[SYNC_STAGES-1] & r_sync[SYNC_STAGES-1]);
            r_cnt    <= (w_in == r_stable || w_flip) ? '0 : r_cnt + 1'b1;
            r_stable <= w_flip ? w_in : r_stable;
            r_press  <= w_flip & ~w_in;
        end
    end

    assign o_level = ~r_stable;
    assign o_press = r_press;
endmodule

// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: conditions the board buttons and runs the menu/play/pause/
// lose/win mode machine with optional auto-return from the game-over screens.
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_GAMES       = 3,
    parameter int OVER_TIMEOUT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    game_mode_ctrl_if.slave  bus
);
    localparam int GW = gid_w(NUM_GAMES);
    localparam logic [GW-1:0] GMAX = GW'(NUM_GAMES - 1);
    localparam int TW = $clog2(OVER_TIMEOUT + 1) + 1;
    localparam logic [TW-1:0] TLAST = TW'((OVER_TIMEOUT > 0) ? OVER_TIMEOUT - 1 : 0);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    mode_t              r_mode;
    mode_t              w_mode;
    logic [GW-1:0]      r_game;
    logic [GW-1:0]      w_game;
    logic               r_start;
    logic               w_start;
    logic [TW-1:0]      r_timer;
    logic [TW-1:0]      w_timer;
    logic               w_confirm;
    logic               w_prev;
    logic               w_next;
    logic               w_pause;
    logic               w_expired;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk     (clk),
                .rst     (rst),
                .i_btn_n (bus.btn_n[i]),
                .o_level (w_level[i]),
                .o_press (w_press[i])
            );
        end
    endgenerate

    assign w_confirm = w_press[BTN_CONFIRM];
    assign w_prev    = w_press[BTN_PREV];
    assign w_next    = w_press[BTN_NEXT];
    assign w_pause   = w_press[BTN_PAUSE];
    assign w_expired = (OVER_TIMEOUT > 0) && (r_timer == TLAST);

    // r_game is the cursor in MENU and the latched selection elsewhere, so
    // returning to MENU naturally resumes from the last game played
    always_comb begin
        w_mode  = r_mode;
        w_game  = r_game;
        w_start = 1'b0;
        w_timer = '0;
        case (r_mode)
            MODE_MENU: begin
                if (w_confirm) begin
                    w_mode  = MODE_PLAY;
                    w_start = 1'b1;
                end else if (w_prev) begin
                    w_game = (r_game == '0) ? GMAX : r_game - 1'b1;
                end else if (w_next) begin
                    w_game = (r_game == GMAX) ? '0 : r_game + 1'b1;
                end
            end
            MODE_PLAY:  w_mode = bus.lose ? MODE_LOSE : bus.win ? MODE_WIN : w_pause ? MODE_PAUSE : MODE_PLAY;
            MODE_PAUSE: w_mode = w_confirm ? MODE_MENU : w_pause ? MODE_PLAY : MODE_PAUSE;
            MODE_LOSE, MODE_WIN: begin
                w_timer = r_timer + 1'b1;
                w_mode  = (w_confirm || w_expired) ? MODE_MENU : r_mode;
            end
            default:    w_mode = MODE_MENU;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= MODE_MENU;
            r_game  <= '0;
            r_start <= 1'b0;
            r_timer <= '0;
        end else begin
            r_mode  <= w_mode;
            r_game  <= w_game;
            r_start <= w_start;
            r_timer <= w_timer;
        end
    end

    assign bus.btn_level  = w_level;
    assign bus.btn_press  = w_press;
    assign bus.mode       = r_mode;
    assign bus.game_id    = r_game;
    assign bus.game_start = r_start;
endmodule

// File: doc/game_mode_ctrl.md
Name: game_mode_ctrl

Overview:
- Parametrised front-end and mode controller for the VGA game board.
- Conditions NUM_BTN raw active-low push-buttons: synchroniser, per-button debounce, one-cycle press pulses.
- Runs the top-level game-mode state machine: menu with wrap-around cursor, play, pause, lose/win screens with optional auto-return.
- Sits between the board pins and the renderers (start/end screen, game cores); replaces ad-hoc edge detection and mode logic in board tops.

Parameters:
- NUM_BTN, 5, number of raw buttons; must be >= 4.
- SYNC_STAGES, 2, synchroniser flops per button; must be >= 2.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a new level (5 ms at 50 MHz); must be >= 1.
- NUM_GAMES, 3, selectable games; must be >= 1.
- OVER_TIMEOUT, 0, cycles in a game-over state before auto-return to menu; 0 disables auto-return.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- btn_n  in  NUM_BTN  raw buttons, active-low (0 = pressed); bit0 confirm, bit1 prev, bit2 next, bit3 pause; higher bits are conditioned only.
- lose  in  1  level from the game core; sampled only in PLAY.
- win  in  1  level from the game core; sampled only in PLAY.
- btn_level  out  NUM_BTN  debounced state, active-high (1 = pressed).
- btn_press  out  NUM_BTN  one-cycle pulse on each debounced press.
- mode  out  3  0 MENU, 1 PLAY, 2 PAUSE, 3 LOSE, 4 WIN.
- game_id  out  clog2(NUM_GAMES) (min 1)  menu cursor in MENU; the latched selection in all other states.
- game_start  out  1  one-cycle pulse on entry to PLAY from MENU; game cores reset on it.

Behaviour:
- Reset (async assert, sync release): sync flops = 1 (released); debounced = released; all counters = 0; btn_level = 0; btn_press = 0; mode = MENU; game_id = 0; game_start = 0.
- Synchroniser: SYNC_STAGES flops per bit. No combinational path from btn_n to any output.
- Debounce, per button:
  - Counter clears whenever the synchronised level equals the accepted level.
  - Otherwise the counter increments. At count DEBOUNCE_CYCLES-1 the accepted level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clears the count and produces no change.
- btn_press[i] is high for exactly the one cycle in which btn_level[i] goes 0 -> 1. Releases produce no pulse.
- Latency: pin edge -> btn_level/btn_press after SYNC_STAGES + DEBOUNCE_CYCLES cycles. btn_press -> mode change is registered, visible the next cycle.
- FSM uses btn_press only; a held button never auto-repeats.
  - MENU:
    - prev -> cursor-1, wrapping 0 -> NUM_GAMES-1.
    - next -> cursor+1, wrapping NUM_GAMES-1 -> 0.
    - confirm -> PLAY; game_id latched; game_start pulses for one cycle.
    - Priority: confirm > prev > next. Simultaneous prev+next with no confirm -> prev only.
    - NUM_GAMES = 1: cursor stays 0.
  - PLAY:
    - lose -> LOSE; win -> WIN. Both in the same cycle -> LOSE.
    - Otherwise pause press -> PAUSE.
    - lose/win take priority over pause in the same cycle.
  - PAUSE: pause press -> PLAY; confirm -> MENU (abort); both together -> MENU. lose/win ignored.
  - LOSE/WIN:
    - confirm -> MENU.
    - If OVER_TIMEOUT > 0, a timer clears on entry and, after OVER_TIMEOUT cycles in state, forces MENU.
    - Confirm on the expiry cycle -> MENU, same result.
  - MENU entry: cursor set to the last game_id so the previous selection is kept.
- Reset asserted mid-debounce or mid-game returns everything to reset values immediately. No press pulse is generated on release, even if a button is held: the held button must be released and pressed again to register.
- Illegal mode encodings (5-7) recover to MENU on the next cycle.

Decomposition:
- Shared package game_pkg holds:
  - mode encoding constants MODE_MENU, MODE_PLAY, MODE_PAUSE, MODE_LOSE, MODE_WIN;
  - button index constants BTN_CONFIRM, BTN_PREV, BTN_NEXT, BTN_PAUSE;
  - the 3-bit mode typedef.
- Sub-module btn_debounce, one instance per button via generate: synchroniser + counter + level + press pulse, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
- FSM and over-screen timer stay in game_mode_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_GAMES=3, OVER_TIMEOUT=20):
- btn_n[0] low for 3 cycles, then high -> no btn_level/btn_press change. Low for 10 cycles -> btn_press[0] is a single pulse, 6 cycles after the edge; btn_level[0] = 1 until release is debounced.
- In MENU: next x3 -> game_id 1, 2, 0. Prev from 0 -> 2. Prev+next together from 0 -> 2.
- Select game 2, press confirm -> mode=1 next cycle, game_id=2, game_start high exactly 1 cycle. Hold confirm 100 cycles -> no further transitions.
- In PLAY, assert lose and win together with a pause press -> mode=3. Leave it untouched -> mode=0 after 20 cycles, game_id=2.
- PLAY -> pause -> mode=2. Assert win -> still 2. Pause -> 1. Win -> 4. Confirm -> 0.
- Assert rst mid-PLAY while btn_n[0] is held low -> all outputs at reset values. After release, no btn_press[0] until the button is released and pressed again.
